alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width; only 8 is verified.
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port op  input  4  opcode, captured with start.
REQ-006 SHALL have ports a, b  input  DATA_W  operands, captured with start.
REQ-007 SHALL have port cin  input  1  carry-in for ADC/SBC, captured with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result/flags valid in that cycle.
REQ-010 SHALL have port result  output  DATA_W  registered result; feeds the flag register's compare input.
REQ-011 SHALL have ports overflow, carry  output  1  registered flags; feed the flag register.
REQ-012 SHALL have port flag_we  output  1  equals done; drives the flag register's write enable.

Function
REQ-013 SHALL decode op: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT a, 8 SHL a, 9 SHR a, A MUL, B DIV, C MOD; D-F undefined.
REQ-014 SHALL use states IDLE, ITER, DONE; IDLE->DONE for single-cycle ops, IDLE->ITER for MUL/DIV/MOD, ITER->DONE after DATA_W iterations, DONE->IDLE unconditionally.
REQ-015 SHALL assert done exactly 1 cycle after accepted start for single-cycle ops and DATA_W+1 cycles after for MUL/DIV/MOD.
REQ-016 SHALL ignore start while busy=1 or done=1; a new start is accepted in the cycle after done.
REQ-017 SHALL set, for ADD/ADC: carry = unsigned carry-out, overflow = signed overflow.
REQ-018 SHALL set, for SUB/SBC (a-b-cin): carry = 1 on unsigned borrow, overflow = signed overflow.
REQ-019 SHALL set, for SHL: carry = a[MSB]; for SHR (logical): carry = a[0]; overflow = 0 for both.
REQ-020 SHALL set, for logic ops and undefined ops: carry = 0, overflow = 0; undefined ops yield result 0.
REQ-021 SHALL compute MUL by shift-add, one bit per cycle; result = low byte; carry = (high byte != 0); overflow = 0.
REQ-022 SHALL compute DIV/MOD by restoring division, one bit per cycle; DIV result = quotient, MOD result = remainder; carry = 0, overflow = 0.
REQ-023 SHALL handle b = 0 for DIV/MOD: DIV result all-ones, MOD result = a, overflow = 1, carry = 0, same latency as non-zero divide.
REQ-024 SHALL hold result/overflow/carry stable from done until the next done.

Reset
REQ-025 SHALL on reset (any time, including mid-ITER) force state IDLE, busy=0, done=0, flag_we=0, result=0, overflow=0, carry=0, iteration counter 0.
REQ-026 SHALL accept a start in the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL compile the DIV/MOD datapath only when macro ALU_SEQ_DIV_EN is defined.
REQ-028 SHALL, without ALU_SEQ_DIV_EN, treat opcodes B and C as undefined ops (single cycle, result 0, flags 0).

Structure
REQ-029 SHALL take opcode enumeration and state encoding from the shared CPU package.
REQ-030 SHALL place the iterative multiply/divide datapath in one sub-module, alu_seq_iter.

Verification
REQ-031 ADD a=0x7F b=0x01 -> done at +1, result 0x80, overflow=1, carry=0, flag_we=1.
REQ-032 SUB a=0x05 b=0x07 -> result 0xFE, carry=1, overflow=0; SBC a=0x10 b=0x00 cin=1 -> result 0x0F, carry=0.
REQ-033 MUL a=0x10 b=0x20 -> done at +9, result 0x00, carry=1; start pulsed at +3 ignored.
REQ-034 DIV a=200 b=7 -> 28 (0x1C); MOD -> 4; DIV b=0 -> 0xFF, overflow=1; both done at +9.
REQ-035 reset asserted at +4 of MUL -> busy=0, result=0, no done; ADD 0x01+0x01 afterwards -> 0x02 at +1.
REQ-036 build without ALU_SEQ_DIV_EN, DIV a=200 b=7 -> done at +1, result 0x00, flags 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode enumeration, FSM state encoding and opcode
// classification for the sequential ALU.
//
// Optional feature macro: ALU_SEQ_DIV_EN. When it is defined, DIV and MOD
// take the iterative path. When it is not defined, those opcodes are
// treated as undefined single-cycle ops.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_ADC = 4'h2,
    OP_SBC = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_NOT = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9,
    OP_MUL = 4'hA,
    OP_DIV = 4'hB,
    OP_MOD = 4'hC
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Returns 1 for opcodes that use the multi-cycle datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: iterative datapath that processes one bit per step.
//   MUL : shift-add. {hi,lo} starts as {0,b}. After DATA_W steps it holds a*b.
//   DIV/MOD (ALU_SEQ_DIV_EN only) : restoring division. lo starts as the
//         dividend. After DATA_W steps, lo = quotient and hi = remainder.
// Ports: clk, reset (async, high); load captures a/b/is_div; step advances
// the datapath by one bit; lo_nxt/hi_nxt show the value that the registers
// take on this edge, so the caller can register the final result on the
// last step.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo_nxt,
  output logic [DATA_W-1:0] hi_nxt
);

  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV/MOD)
  logic [DATA_W:0]   mul_sum;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

`ifdef ALU_SEQ_DIV_EN
  logic            div_q, div_d;
  logic [DATA_W:0] div_shift;
  logic [DATA_W:0] div_diff;

  assign div_shift = {hi_q, lo_q[DATA_W-1]};
  // The MSB of div_diff is set exactly when div_shift < divisor. With a zero
  // divisor, every step subtracts, so the quotient becomes all-ones and the
  // remainder becomes the dividend.
  assign div_diff  = div_shift - {1'b0, opnd_q};
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
`endif

  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    opnd_d = opnd_q;
`ifdef ALU_SEQ_DIV_EN
    div_d  = div_q;
`endif
    if (load) begin
      hi_d = '0;
`ifdef ALU_SEQ_DIV_EN
      div_d  = is_div;
      lo_d   = is_div ? a : b;
      opnd_d = is_div ? b : a;
`else
      lo_d   = b;
      opnd_d = a;
`endif
    end else if (step) begin
`ifdef ALU_SEQ_DIV_EN
      if (div_q) begin
        if (!div_diff[DATA_W]) begin
          hi_d = div_diff[DATA_W-1:0];
          lo_d = {lo_q[DATA_W-2:0], 1'b1};
        end else begin
          hi_d = div_shift[DATA_W-1:0];
          lo_d = {lo_q[DATA_W-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {mul_sum, lo_q[DATA_W-1:1]};
      end
`else
      {hi_d, lo_d} = {mul_sum, lo_q[DATA_W-1:1]};
`endif
    end
  end

  assign lo_nxt = lo_d;
  assign hi_nxt = hi_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q   <= '0;
      hi_q   <= '0;
      opnd_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      opnd_q <= opnd_d;
`ifdef ALU_SEQ_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with the FSM IDLE -> (ITER) -> DONE -> IDLE.
// Single-cycle ops assert done 1 cycle after the start is accepted.
// MUL (and DIV/MOD when ALU_SEQ_DIV_EN is defined) assert done DATA_W+1
// cycles after the start is accepted.
// Handshake: start is sampled only in IDLE. busy is high from the cycle
// after the accepted start through the done cycle. done is a 1-cycle pulse.
// result/overflow/carry are valid on done and hold until the next done.
// flag_we mirrors done.
// Ports: clk, reset (async, active-high), start, op[3:0], a, b, cin ->
//        busy, done, result, overflow, carry, flag_we, dbg_state (FSM state).
// Optional macro: ALU_SEQ_DIV_EN enables the DIV/MOD datapath.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              carry,
  output logic              flag_we,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam int MSB = DATA_W - 1;

  alu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              carry_q, carry_d;
`ifdef ALU_SEQ_DIV_EN
  logic [3:0]        op_q, op_d;
  logic              bzero_q, bzero_d;
`endif

  logic              iter_load, iter_step;
  logic [DATA_W-1:0] lo_nxt, hi_nxt;

  // Single-cycle ops. The return value is {overflow, carry, result}.
  function automatic logic [DATA_W+1:0] single_op(input logic [3:0] o,
      input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y, input logic ci);
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] r;
    logic              v, c;
    wide = '0;
    r    = '0;
    v    = 1'b0;
    c    = 1'b0;
    case (o)
      OP_ADD, OP_ADC: begin
        wide = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, (o == OP_ADC) & ci};
        r = wide[DATA_W-1:0];
        c = wide[DATA_W];
        v = (x[MSB] == y[MSB]) && (r[MSB] != x[MSB]);
      end
      OP_SUB, OP_SBC: begin
        // A borrow out of the top bit shows up as wide[DATA_W].
        wide = {1'b0, x} - {1'b0, y} - {{DATA_W{1'b0}}, (o == OP_SBC) & ci};
        r = wide[DATA_W-1:0];
        c = wide[DATA_W];
        v = (x[MSB] != y[MSB]) && (r[MSB] != x[MSB]);
      end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_NOT: r = ~x;
      OP_SHL: begin r = {x[DATA_W-2:0], 1'b0}; c = x[MSB]; end
      OP_SHR: begin r = {1'b0, x[DATA_W-1:1]}; c = x[0]; end
      default: r = '0;
    endcase
    return {v, c, r};
  endfunction

  alu_seq_iter #(.DATA_W(DATA_W)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (iter_load),
    .step   (iter_step),
    .is_div ((op == OP_DIV) || (op == OP_MOD)),
    .a      (a),
    .b      (b),
    .lo_nxt (lo_nxt),
    .hi_nxt (hi_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    ovf_d     = ovf_q;
    carry_d   = carry_q;
    iter_load = 1'b0;
    iter_step = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    op_d      = op_q;
    bzero_d   = bzero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (is_iter_op(op)) begin
            state_d   = ST_ITER;
            cnt_d     = '0;
            iter_load = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            op_d      = op;
            bzero_d   = (b == '0);
`endif
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            {ovf_d, carry_d, result_d} = single_op(op, a, b, cin);
          end
        end
      end
      ST_ITER: begin
        iter_step = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Register the final step's value in the same edge that completes it.
          state_d  = ST_DONE;
          done_d   = 1'b1;
          cnt_d    = '0;
          result_d = lo_nxt;
          carry_d  = |hi_nxt;
          ovf_d    = 1'b0;
`ifdef ALU_SEQ_DIV_EN
          if (op_q == OP_DIV || op_q == OP_MOD) begin
            // A zero divisor needs no special datapath. It naturally gives
            // quotient all-ones and remainder = dividend.
            result_d = (op_q == OP_MOD) ? hi_nxt : lo_nxt;
            carry_d  = 1'b0;
            ovf_d    = bzero_q;
          end
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      op_q     <= '0;
      bzero_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
`ifdef ALU_SEQ_DIV_EN
      op_q     <= op_d;
      bzero_q  <= bzero_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign flag_we   = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign carry     = carry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: testbench for alu_seq (DATA_W = 8). Each driven operation
// pushes its expected {result, overflow, carry} onto exp_q. When done
// arrives, the bench pops the entry and compares it with the outputs.
// The bench also checks done latency, flag_we, the hold after done,
// reset behaviour, and the effect of ALU_SEQ_DIV_EN.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, cin;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, overflow, carry, flag_we;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W+1:0] exp_q[$];   // {result, overflow, carry}

  alu_seq #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .carry(carry), .flag_we(flag_we), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] pack(input logic [W-1:0] r, input logic v, input logic c);
    return {r, v, c};
  endfunction

  // Reference model built from integer arithmetic.
  function automatic logic [W+1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic ci);
    int ux, uy, sx, sy, cc, r, s;
    logic [W-1:0] res;
    logic v, c;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    cc = (o == 4'h2 || o == 4'h3) ? int'(ci) : 0;
    res = '0; v = 1'b0; c = 1'b0;
    case (o)
      4'h0, 4'h2: begin
        r = ux + uy + cc; res = r[W-1:0]; c = (r > 255);
        s = sx + sy + cc; v = (s > 127) || (s < -128);
      end
      4'h1, 4'h3: begin
        r = ux - uy - cc; res = r[W-1:0]; c = (r < 0);
        s = sx - sy - cc; v = (s > 127) || (s < -128);
      end
      4'h4: res = x & y;
      4'h5: res = x | y;
      4'h6: res = x ^ y;
      4'h7: res = ~x;
      4'h8: begin r = ux * 2; res = r[W-1:0]; c = x[7]; end
      4'h9: begin res = x >> 1; c = x[0]; end
      4'hA: begin r = ux * uy; res = r[W-1:0]; c = (r > 255); end
`ifdef ALU_SEQ_DIV_EN
      4'hB: if (uy == 0) begin res = 8'hFF; v = 1'b1; end else begin r = ux / uy; res = r[W-1:0]; end
      4'hC: if (uy == 0) begin res = x; v = 1'b1; end else begin r = ux % uy; res = r[W-1:0]; end
`endif
      default: res = '0;
    endcase
    return {res, v, c};
  endfunction

  function automatic int lat_of(input logic [3:0] o);
    if (o == 4'hA) return 9;
`ifdef ALU_SEQ_DIV_EN
    if (o == 4'hB || o == 4'hC) return 9;
`endif
    return 1;
  endfunction

  // Drives one operation, then waits (bounded) for done and scores it.
  // If ign_at > 0, a spurious start pulse is driven in that cycle and must
  // be ignored.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci, input logic [W+1:0] exp,
                        input int lat, input int ign_at);
    logic [W+1:0] e;
    int k;
    bit seen;
    exp_q.push_back(exp);
    op = o; a = x; b = y; cin = ci; start = 1'b1;
    @(negedge clk);
    // Scramble the inputs so that a missing operand capture is detected.
    start = 1'b0; op = 4'h0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      start = (k == ign_at);
      if (k == 1 && lat > 1) check({tag, " busy"}, 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = exp_q.pop_front();
    if (!seen) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, " lat"}, 32'(k), 32'(lat));
    check({tag, " result"}, 32'(result), 32'(e[W+1:2]));
    check({tag, " overflow"}, 32'(overflow), 32'(e[1]));
    check({tag, " carry"}, 32'(carry), 32'(e[0]));
    check({tag, " flag_we"}, 32'(flag_we), 32'd1);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " hold"}, 32'(result), 32'(e[W+1:2]));
  endtask

  initial begin
    logic [3:0] o;
    logic [W-1:0] x, y;
    logic ci;
    int done_seen;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst flag_we", 32'(flag_we), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst flags", 32'({overflow, carry}), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    run_op("add_ovf", 4'h0, 8'h7F, 8'h01, 1'b0, pack(8'h80, 1'b1, 1'b0), 1, 0);
    run_op("sub_borrow", 4'h1, 8'h05, 8'h07, 1'b0, pack(8'hFE, 1'b0, 1'b1), 1, 0);
    run_op("sbc_cin", 4'h3, 8'h10, 8'h00, 1'b1, pack(8'h0F, 1'b0, 1'b0), 1, 0);
    run_op("mul_hi", 4'hA, 8'h10, 8'h20, 1'b0, pack(8'h00, 1'b0, 1'b1), 9, 3);
    run_op("shl", 4'h8, 8'h81, 8'h00, 1'b0, pack(8'h02, 1'b0, 1'b1), 1, 0);
    run_op("shr", 4'h9, 8'h81, 8'h00, 1'b0, pack(8'h40, 1'b0, 1'b1), 1, 0);
    run_op("undef_f", 4'hF, 8'hFF, 8'hFF, 1'b1, pack(8'h00, 1'b0, 1'b0), 1, 0);
`ifdef ALU_SEQ_DIV_EN
    run_op("div", 4'hB, 8'd200, 8'd7, 1'b0, pack(8'h1C, 1'b0, 1'b0), 9, 0);
    run_op("mod", 4'hC, 8'd200, 8'd7, 1'b0, pack(8'h04, 1'b0, 1'b0), 9, 0);
    run_op("div_zero", 4'hB, 8'd200, 8'd0, 1'b0, pack(8'hFF, 1'b1, 1'b0), 9, 0);
    run_op("mod_zero", 4'hC, 8'd200, 8'd0, 1'b0, pack(8'd200, 1'b1, 1'b0), 9, 0);
`else
    run_op("div_off", 4'hB, 8'd200, 8'd7, 1'b0, pack(8'h00, 1'b0, 1'b0), 1, 0);
    run_op("mod_off", 4'hC, 8'd200, 8'd7, 1'b0, pack(8'h00, 1'b0, 1'b0), 1, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(0, 15));
      x = W'($urandom_range(0, 255));
      y = W'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d_op%0h", i, o), o, x, y, ci, model(o, x, y, ci), lat_of(o), 0);
    end

    // Reset during MUL iteration, at cycle +4 after the accepted start.
    op = 4'hA; a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst result", 32'(result), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst state", 32'(dbg_state), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrst no_done", 32'(done_seen), 32'd0);
    reset = 1'b0;
    run_op("add_after_rst", 4'h0, 8'h01, 8'h01, 1'b0, pack(8'h02, 1'b0, 1'b0), 1, 0);

    check("exp_q empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
